// File: rtl/dma_write_engine.sv
// Avalon-MM burst write engine: queues write commands, drains the DMA data FIFO
// into bursts of up to MAX_BURST beats and posts one status word per command.
module dma_write_engine #(
    parameter int unsigned DATA_W    = 256,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned MAX_BURST = 16,
    parameter int unsigned CMD_DEPTH = 32
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       cmd_wr_req_i,
    input  logic [15:0]                cmd_bytes_i,
    input  logic [ADDR_W-1:0]          cmd_addr_i,
    input  logic [7:0]                 cmd_desc_id_i,
    input  logic                       cmd_owned_by_hw_i,
    output logic                       cmd_fifo_full_o,
    input  logic [DATA_W-1:0]          data_i,
    input  logic                       data_fifo_empty_i,
    output logic                       data_fifo_rd_req_o,
    output logic [ADDR_W-1:0]          wr_master_addr_o,
    output logic                       wr_master_write_o,
    output logic [$clog2(MAX_BURST):0] wr_master_burstcount_o,
    output logic [DATA_W-1:0]          wr_master_data_o,
    output logic [DATA_W/8-1:0]        wr_master_byteenable_o,
    input  logic                       wr_master_wait_req_i,
    output logic                       status_wr_req_o,
    output logic [24:0]                status_data_o,
    input  logic                       status_almost_full_i
);

    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned BL    = $clog2(BYTES);
    localparam int unsigned BW    = 17 - BL;
    localparam int unsigned BCW   = $clog2(MAX_BURST) + 1;
    localparam int unsigned PW    = $clog2(CMD_DEPTH);
    localparam int unsigned CW    = 16 + ADDR_W + 9;
    localparam logic [BYTES-1:0] ONES = '1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETUP, S_BURST, S_STATUS} state_t;

    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync_q <= '0;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    logic [CW-1:0] cmd_mem [CMD_DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [PW:0]   cnt_q;
    logic          push, pop;
    logic [CW-1:0] head;
    logic [15:0]   head_bytes;
    logic [ADDR_W-1:0] head_addr;
    logic [7:0]    head_id;
    logic          head_hw;
    logic [16:0]   ceil_sum;
    logic [BW-1:0] head_beats;

    state_t            state_q, state_d;
    logic [15:0]       bytes_q, bytes_d;
    logic [7:0]        id_q, id_d;
    logic              hw_q, hw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BW-1:0]     beats_left_q, beats_left_d;
    logic [BW-1:0]     out_left_q, out_left_d;
    logic [BCW-1:0]    burst_len_q, burst_len_d;
    logic [BCW-1:0]    req_cnt_q, req_cnt_d;
    logic [BCW-1:0]    acc_cnt_q, acc_cnt_d;
    logic              inflight_q, inflight_d;
    logic [DATA_W-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
    logic [1:0]        buf_cnt_q, buf_cnt_d;
    logic              write_q, write_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [BYTES-1:0]  be_q, be_d;
    logic [ADDR_W-1:0] maddr_q, maddr_d;
    logic [BCW-1:0]    mbc_q, mbc_d;

    logic              rd_req, out_free, accept, load_beat;
    logic [DATA_W-1:0] load_src;
    logic [BCW-1:0]    burst_min;
    logic [BL:0]       be_shift;
    logic [BYTES-1:0]  last_be;

    assign push       = cmd_wr_req_i & ~cmd_fifo_full_o;
    assign pop        = (state_q == S_LOAD);
    assign head       = cmd_mem[rptr_q];
    assign head_bytes = head[15:0];
    assign head_addr  = head[16 +: ADDR_W];
    assign head_id    = head[16 + ADDR_W +: 8];
    assign head_hw    = head[CW-1];
    // 17-bit sum keeps ceil() exact for 65535 bytes
    assign ceil_sum   = {1'b0, head_bytes} + 17'(BYTES - 1);
    assign head_beats = ceil_sum[16:BL];

    always_ff @(posedge clk) begin
        if (push) cmd_mem[wptr_q] <= {cmd_owned_by_hw_i, cmd_desc_id_i, cmd_addr_i, cmd_bytes_i};
    end

    assign be_shift = (BL + 1)'(BYTES) - {1'b0, bytes_q[BL-1:0]};
    assign last_be  = ONES >> be_shift;

    always_comb begin
        if (32'(beats_left_q) > 32'(MAX_BURST)) burst_min = BCW'(MAX_BURST);
        else                                    burst_min = BCW'(beats_left_q);
    end

    always_comb begin
        state_d      = state_q;
        bytes_d      = bytes_q;
        id_d         = id_q;
        hw_d         = hw_q;
        addr_d       = addr_q;
        beats_left_d = beats_left_q;
        out_left_d   = out_left_q;
        burst_len_d  = burst_len_q;
        req_cnt_d    = req_cnt_q;
        acc_cnt_d    = acc_cnt_q;
        buf0_d       = buf0_q;
        buf1_d       = buf1_q;
        buf_cnt_d    = buf_cnt_q;
        write_d      = write_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        maddr_d      = maddr_q;
        mbc_d        = mbc_q;
        load_beat    = 1'b0;
        load_src     = data_i;
        status_wr_req_o = 1'b0;

        rd_req = (state_q == S_BURST) & ~data_fifo_empty_i
               & ((buf_cnt_q + {1'b0, inflight_q}) < 2'd2)
               & (req_cnt_q < burst_len_q);
        inflight_d = rd_req;
        if (rd_req) req_cnt_d = req_cnt_q + BCW'(1);

        // Output register refills from the buffer head first, else straight from the FIFO
        out_free = ~write_q | ~wr_master_wait_req_i;
        accept   = write_q & ~wr_master_wait_req_i;
        if (out_free) begin
            if (buf_cnt_q != 2'd0) begin
                load_beat = 1'b1;
                load_src  = buf0_q;
                buf0_d    = buf1_q;
                if (inflight_q) begin
                    if (buf_cnt_q == 2'd1) buf0_d = data_i;
                    else                   buf1_d = data_i;
                end else begin
                    buf_cnt_d = buf_cnt_q - 2'd1;
                end
            end else if (inflight_q) begin
                load_beat = 1'b1;
            end
        end else if (inflight_q) begin
            if (buf_cnt_q == 2'd0) buf0_d = data_i;
            else                   buf1_d = data_i;
            buf_cnt_d = buf_cnt_q + 2'd1;
        end

        if (load_beat) begin
            write_d    = 1'b1;
            wdata_d    = load_src;
            be_d       = (out_left_q == BW'(1) && bytes_q[BL-1:0] != '0) ? last_be : '1;
            out_left_d = out_left_q - BW'(1);
        end else if (out_free) begin
            write_d = 1'b0;
        end

        case (state_q)
            S_IDLE: if (cnt_q != '0) state_d = S_LOAD;
            S_LOAD: begin
                bytes_d      = head_bytes;
                id_d         = head_id;
                hw_d         = head_hw;
                addr_d       = head_addr;
                beats_left_d = head_beats;
                out_left_d   = head_beats;
                state_d      = (head_beats == '0) ? S_STATUS : S_SETUP;
            end
            S_SETUP: begin
                burst_len_d = burst_min;
                mbc_d       = burst_min;
                maddr_d     = addr_q;
                req_cnt_d   = '0;
                acc_cnt_d   = '0;
                state_d     = S_BURST;
            end
            S_BURST: if (accept) begin
                acc_cnt_d = acc_cnt_q + BCW'(1);
                if (acc_cnt_q == burst_len_q - BCW'(1)) begin
                    addr_d       = addr_q + (ADDR_W'(burst_len_q) << BL);
                    beats_left_d = beats_left_q - BW'(burst_len_q);
                    state_d      = (beats_left_q == BW'(burst_len_q)) ? S_STATUS : S_SETUP;
                end
            end
            S_STATUS: if (!status_almost_full_i) begin
                status_wr_req_o = 1'b1;
                state_d         = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            wptr_q       <= '0;
            rptr_q       <= '0;
            cnt_q        <= '0;
            bytes_q      <= '0;
            id_q         <= '0;
            hw_q         <= 1'b0;
            addr_q       <= '0;
            beats_left_q <= '0;
            out_left_q   <= '0;
            burst_len_q  <= '0;
            req_cnt_q    <= '0;
            acc_cnt_q    <= '0;
            inflight_q   <= 1'b0;
            buf0_q       <= '0;
            buf1_q       <= '0;
            buf_cnt_q    <= '0;
            write_q      <= 1'b0;
            wdata_q      <= '0;
            be_q         <= '1;
            maddr_q      <= '0;
            mbc_q        <= '0;
        end else begin
            state_q      <= state_d;
            wptr_q       <= wptr_q + PW'(push);
            rptr_q       <= rptr_q + PW'(pop);
            cnt_q        <= cnt_q + (PW + 1)'(push) - (PW + 1)'(pop);
            bytes_q      <= bytes_d;
            id_q         <= id_d;
            hw_q         <= hw_d;
            addr_q       <= addr_d;
            beats_left_q <= beats_left_d;
            out_left_q   <= out_left_d;
            burst_len_q  <= burst_len_d;
            req_cnt_q    <= req_cnt_d;
            acc_cnt_q    <= acc_cnt_d;
            inflight_q   <= inflight_d;
            buf0_q       <= buf0_d;
            buf1_q       <= buf1_d;
            buf_cnt_q    <= buf_cnt_d;
            write_q      <= write_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            maddr_q      <= maddr_d;
            mbc_q        <= mbc_d;
        end
    end

    assign cmd_fifo_full_o        = (cnt_q == (PW + 1)'(CMD_DEPTH));
    assign data_fifo_rd_req_o     = rd_req;
    assign wr_master_addr_o       = maddr_q;
    assign wr_master_write_o      = write_q;
    assign wr_master_burstcount_o = mbc_q;
    assign wr_master_data_o       = wdata_q;
    assign wr_master_byteenable_o = be_q;
    assign status_data_o          = {hw_q, id_q, bytes_q};

endmodule
